// File: rtl/ex_mem_stage.sv
// Execute stage of the 5-stage MIPS pipeline: ALU control, forwarding, ALU,
// branch-target add and destination select, registered into EX/MEM.
module ex_mem_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_stall,
    input  logic          i_flush,
    input  logic          i_valid,
    input  logic          i_MemtoReg,
    input  logic          i_MemWrite,
    input  logic          i_MemRead,
    input  logic          i_Branch,
    input  logic          i_ALUSrc,
    input  logic          i_RegDst,
    input  logic          i_RegWrite,
    input  logic [1:0]    i_ALUOp,
    input  logic [DW-1:0] i_PCplus4,
    input  logic [DW-1:0] i_Rdata1,
    input  logic [DW-1:0] i_Rdata2,
    input  logic [DW-1:0] i_signextImmediate,
    input  logic [RW-1:0] i_RegDst1,
    input  logic [RW-1:0] i_RegDst2,
    input  logic [1:0]    i_fwdA,
    input  logic [1:0]    i_fwdB,
    input  logic [DW-1:0] i_wb_data,
    output logic          o_valid,
    output logic          o_MemtoReg,
    output logic          o_MemWrite,
    output logic          o_MemRead,
    output logic          o_Branch,
    output logic          o_RegWrite,
    output logic          o_Zero,
    output logic [DW-1:0] o_BranchTarget,
    output logic [DW-1:0] o_ALUResult,
    output logic [DW-1:0] o_Wdata,
    output logic [RW-1:0] o_WriteReg
);

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_ZERO
    } alu_op_e;

    alu_op_e       alu_op;
    logic [5:0]    funct;
    logic [DW-1:0] op_a;
    logic [DW-1:0] fwd_b;
    logic [DW-1:0] op_b;
    logic [DW-1:0] alu_y;
    logic [DW-1:0] br_tgt;
    logic [RW-1:0] dst_reg;

    assign funct = i_signextImmediate[5:0];

    always_comb begin
        alu_op = ALU_ZERO;
        case (i_ALUOp)
            2'b00: alu_op = ALU_ADD;
            2'b01: alu_op = ALU_SUB;
            2'b11: alu_op = ALU_OR;
            default: begin
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ZERO;
                endcase
            end
        endcase
    end

    // Select 10 forwards the value currently held in EX/MEM; during a stall
    // that value is frozen, so the held result stays self-consistent.
    always_comb begin
        case (i_fwdA)
            2'b01:   op_a = i_wb_data;
            2'b10:   op_a = o_ALUResult;
            default: op_a = i_Rdata1;
        endcase
        case (i_fwdB)
            2'b01:   fwd_b = i_wb_data;
            2'b10:   fwd_b = o_ALUResult;
            default: fwd_b = i_Rdata2;
        endcase
        op_b = i_ALUSrc ? i_signextImmediate : fwd_b;
    end

    always_comb begin
        alu_y = '0;
        case (alu_op)
            ALU_ADD: alu_y = op_a + op_b;
            ALU_SUB: alu_y = op_a - op_b;
            ALU_AND: alu_y = op_a & op_b;
            ALU_OR:  alu_y = op_a | op_b;
            ALU_SLT: alu_y = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: alu_y = '0;
        endcase
    end

    assign br_tgt  = i_PCplus4 + {i_signextImmediate[DW-3:0], 2'b00};
    assign dst_reg = i_RegDst ? i_RegDst2 : i_RegDst1;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            o_valid        <= 1'b0;
            o_MemtoReg     <= 1'b0;
            o_MemWrite     <= 1'b0;
            o_MemRead      <= 1'b0;
            o_Branch       <= 1'b0;
            o_RegWrite     <= 1'b0;
            o_Zero         <= 1'b0;
            o_BranchTarget <= '0;
            o_ALUResult    <= '0;
            o_Wdata        <= '0;
            o_WriteReg     <= '0;
        end else if (!i_stall) begin
            // An invalid slot still carries data, but no control side effects.
            o_valid        <= i_valid;
            o_MemtoReg     <= i_valid & i_MemtoReg;
            o_MemWrite     <= i_valid & i_MemWrite;
            o_MemRead      <= i_valid & i_MemRead;
            o_Branch       <= i_valid & i_Branch;
            o_RegWrite     <= i_valid & i_RegWrite;
            o_Zero         <= (alu_y == '0);
            o_BranchTarget <= br_tgt;
            o_ALUResult    <= alu_y;
            o_Wdata        <= fwd_b;
            o_WriteReg     <= dst_reg;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed literal cases plus randomized traffic
// checked every cycle against a behavioural model of the stage.
module tb_ex_mem_stage;

    logic        i_clk = 1'b0;
    logic        i_rst, i_stall, i_flush, i_valid;
    logic        i_MemtoReg, i_MemWrite, i_MemRead, i_Branch, i_ALUSrc, i_RegDst, i_RegWrite;
    logic [1:0]  i_ALUOp, i_fwdA, i_fwdB;
    logic [31:0] i_PCplus4, i_Rdata1, i_Rdata2, i_signextImmediate, i_wb_data;
    logic [4:0]  i_RegDst1, i_RegDst2;
    logic        o_valid, o_MemtoReg, o_MemWrite, o_MemRead, o_Branch, o_RegWrite, o_Zero;
    logic [31:0] o_BranchTarget, o_ALUResult, o_Wdata;
    logic [4:0]  o_WriteReg;

    always #5 i_clk = ~i_clk;

    ex_mem_stage #(.DW(32), .RW(5)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush),
        .i_valid(i_valid), .i_MemtoReg(i_MemtoReg), .i_MemWrite(i_MemWrite),
        .i_MemRead(i_MemRead), .i_Branch(i_Branch), .i_ALUSrc(i_ALUSrc),
        .i_RegDst(i_RegDst), .i_RegWrite(i_RegWrite), .i_ALUOp(i_ALUOp),
        .i_PCplus4(i_PCplus4), .i_Rdata1(i_Rdata1), .i_Rdata2(i_Rdata2),
        .i_signextImmediate(i_signextImmediate), .i_RegDst1(i_RegDst1),
        .i_RegDst2(i_RegDst2), .i_fwdA(i_fwdA), .i_fwdB(i_fwdB),
        .i_wb_data(i_wb_data), .o_valid(o_valid), .o_MemtoReg(o_MemtoReg),
        .o_MemWrite(o_MemWrite), .o_MemRead(o_MemRead), .o_Branch(o_Branch),
        .o_RegWrite(o_RegWrite), .o_Zero(o_Zero), .o_BranchTarget(o_BranchTarget),
        .o_ALUResult(o_ALUResult), .o_Wdata(o_Wdata), .o_WriteReg(o_WriteReg)
    );

    typedef struct packed {
        logic        valid, mtr, mw, mr, br, rw, zero;
        logic [31:0] bt, alu, wd;
        logic [4:0]  wr;
    } exp_t;

    exp_t exp_s = '0;
    int   total = 0;
    int   bad   = 0;
    bit   done  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_val,
                                         input logic [31:0] prev);
        if (sel == 2'd1) return i_wb_data;
        if (sel == 2'd2) return prev;
        return reg_val;
    endfunction

    function automatic exp_t model_next(input exp_t cur);
        exp_t        n;
        logic [31:0] a, fb, b, y;
        n = '0;
        if (i_rst || i_flush) return n;
        if (i_stall) return cur;
        a  = pick(i_fwdA, i_Rdata1, cur.alu);
        fb = pick(i_fwdB, i_Rdata2, cur.alu);
        b  = i_ALUSrc ? i_signextImmediate : fb;
        y  = 32'd0;
        if (i_ALUOp == 2'd0) y = a + b;
        else if (i_ALUOp == 2'd1) y = a - b;
        else if (i_ALUOp == 2'd3) y = a | b;
        else begin
            case (i_signextImmediate[5:0])
                6'd32: y = a + b;
                6'd34: y = a - b;
                6'd36: y = a & b;
                6'd37: y = a | b;
                6'd42: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default: y = 32'd0;
            endcase
        end
        n.alu   = y;
        n.zero  = (y == 32'd0);
        n.wd    = fb;
        n.bt    = i_PCplus4 + (i_signextImmediate * 32'd4);
        n.wr    = i_RegDst ? i_RegDst2 : i_RegDst1;
        n.valid = i_valid;
        n.mtr   = i_valid && i_MemtoReg;
        n.mw    = i_valid && i_MemWrite;
        n.mr    = i_valid && i_MemRead;
        n.br    = i_valid && i_Branch;
        n.rw    = i_valid && i_RegWrite;
        return n;
    endfunction

    // Per-cycle compare against the model.
    always @(posedge i_clk) begin
        exp_t nxt;
        if (!done) begin
            nxt = model_next(exp_s);
            #1;
            exp_s = nxt;
            chk("valid",   {31'd0, o_valid},    {31'd0, exp_s.valid});
            chk("memtoreg",{31'd0, o_MemtoReg}, {31'd0, exp_s.mtr});
            chk("memwrite",{31'd0, o_MemWrite}, {31'd0, exp_s.mw});
            chk("memread", {31'd0, o_MemRead},  {31'd0, exp_s.mr});
            chk("branch",  {31'd0, o_Branch},   {31'd0, exp_s.br});
            chk("regwrite",{31'd0, o_RegWrite}, {31'd0, exp_s.rw});
            chk("zero",    {31'd0, o_Zero},     {31'd0, exp_s.zero});
            chk("btarget", o_BranchTarget,      exp_s.bt);
            chk("aluresult", o_ALUResult,       exp_s.alu);
            chk("wdata",   o_Wdata,             exp_s.wd);
            chk("writereg",{27'd0, o_WriteReg}, {27'd0, exp_s.wr});
        end
    end

    task automatic clr();
        i_rst = 0; i_stall = 0; i_flush = 0; i_valid = 0;
        i_MemtoReg = 0; i_MemWrite = 0; i_MemRead = 0; i_Branch = 0;
        i_ALUSrc = 0; i_RegDst = 0; i_RegWrite = 0; i_ALUOp = 2'd0;
        i_PCplus4 = 0; i_Rdata1 = 0; i_Rdata2 = 0; i_signextImmediate = 0;
        i_RegDst1 = 0; i_RegDst2 = 0; i_fwdA = 0; i_fwdB = 0; i_wb_data = 0;
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #2;
    endtask

    task automatic rand_inputs();
        logic [5:0] fn_tab [6];
        fn_tab = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};
        i_rst     = ($urandom_range(0, 49) == 0);
        i_flush   = ($urandom_range(0, 9) == 0);
        i_stall   = ($urandom_range(0, 5) == 0);
        i_valid   = ($urandom_range(0, 3) != 0);
        {i_MemtoReg, i_MemWrite, i_MemRead, i_Branch} = 4'($urandom);
        {i_ALUSrc, i_RegDst, i_RegWrite} = 3'($urandom);
        i_ALUOp   = 2'($urandom);
        i_fwdA    = 2'($urandom);
        i_fwdB    = 2'($urandom);
        i_PCplus4 = $urandom;
        i_Rdata1  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        i_Rdata2  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        i_wb_data = $urandom;
        i_signextImmediate = $urandom;
        if ($urandom_range(0, 3) != 0)
            i_signextImmediate[5:0] = fn_tab[$urandom_range(0, 5)];
        i_RegDst1 = 5'($urandom);
        i_RegDst2 = 5'($urandom);
    endtask

    initial begin
        clr();
        // Reset held for two edges with a live instruction present.
        i_rst = 1; i_valid = 1; i_RegWrite = 1; i_Rdata1 = 32'h11;
        cyc(); cyc();
        chk("rst_valid",    {31'd0, o_valid},    32'd0);
        chk("rst_regwrite", {31'd0, o_RegWrite}, 32'd0);
        chk("rst_alu",      o_ALUResult,         32'd0);

        i_rst = 0; i_ALUOp = 2'd0; i_Rdata1 = 32'd2; i_Rdata2 = 32'd3;
        cyc();
        chk("post_rst_valid", {31'd0, o_valid}, 32'd1);
        chk("post_rst_alu",   o_ALUResult,      32'd5);

        // R-type sub giving zero, rd destination.
        i_ALUOp = 2'd2; i_signextImmediate = 32'h22; i_Rdata1 = 32'd5; i_Rdata2 = 32'd5;
        i_RegDst = 1; i_RegDst2 = 5'd3; i_RegDst1 = 5'd7;
        cyc();
        chk("rsub_alu",  o_ALUResult,            32'd0);
        chk("rsub_zero", {31'd0, o_Zero},        32'd1);
        chk("rsub_wreg", {27'd0, o_WriteReg},    32'd3);

        // Signed slt in both orders.
        i_signextImmediate = 32'h2a; i_Rdata1 = 32'hFFFF_FFFF; i_Rdata2 = 32'd1;
        cyc();
        chk("slt_neg_lt_one", o_ALUResult, 32'd1);
        chk("model_slt",      exp_s.alu,   32'd1);
        i_Rdata1 = 32'd1; i_Rdata2 = 32'hFFFF_FFFF;
        cyc();
        chk("slt_one_lt_neg", o_ALUResult, 32'd0);

        // lw address add with wrapping branch target.
        i_ALUOp = 2'd0; i_ALUSrc = 1; i_Rdata1 = 32'h100; i_signextImmediate = 32'hFFFF_FFFC;
        i_PCplus4 = 32'h4; i_MemRead = 1; i_MemtoReg = 1; i_RegDst = 0;
        cyc();
        chk("lw_alu",     o_ALUResult,    32'h0000_00FC);
        chk("lw_btarget", o_BranchTarget, 32'hFFFF_FFF4);
        chk("model_bt",   exp_s.bt,       32'hFFFF_FFF4);

        // EX/MEM forwarding on operand A.
        i_ALUSrc = 0; i_MemRead = 0; i_MemtoReg = 0; i_signextImmediate = 0; i_PCplus4 = 0;
        i_Rdata1 = 32'd7; i_Rdata2 = 32'd8;
        cyc();
        chk("fwd_first", o_ALUResult, 32'd15);
        i_fwdA = 2'd2; i_Rdata1 = 32'hDEAD_BEEF; i_Rdata2 = 32'd1;
        cyc();
        chk("fwd_exmem", o_ALUResult, 32'd16);

        // Three stalled cycles with changing inputs must hold everything.
        i_stall = 1;
        for (int k = 0; k < 3; k++) begin
            i_Rdata1 = $urandom; i_Rdata2 = $urandom; i_valid = 1'(k);
            cyc();
            chk("stall_hold_alu",   o_ALUResult,     32'd16);
            chk("stall_hold_valid", {31'd0, o_valid}, 32'd1);
        end

        // Writeback forwarding onto store data.
        i_stall = 0; i_fwdA = 0; i_valid = 1; i_Rdata1 = 32'd7; i_Rdata2 = 32'd8;
        cyc();
        chk("fwd_alt_first", o_ALUResult, 32'd15);
        i_fwdB = 2'd1; i_wb_data = 32'd9; i_ALUSrc = 1; i_MemWrite = 1;
        i_signextImmediate = 32'h10; i_Rdata1 = 32'h40; i_Rdata2 = 32'h55;
        cyc();
        chk("fwd_wb_wdata", o_Wdata,     32'd9);
        chk("fwd_wb_alu",   o_ALUResult, 32'h50);

        // Flush beats a simultaneous stall.
        i_stall = 1; i_flush = 1; i_RegWrite = 1;
        cyc();
        chk("flush_valid",    {31'd0, o_valid},    32'd0);
        chk("flush_regwrite", {31'd0, o_RegWrite}, 32'd0);
        chk("flush_memwrite", {31'd0, o_MemWrite}, 32'd0);
        chk("flush_alu",      o_ALUResult,         32'd0);

        // Reset takes effect in the middle of a stall.
        i_stall = 0; i_flush = 0;
        cyc();
        i_stall = 1; i_rst = 1;
        cyc();
        chk("rst_in_stall_valid", {31'd0, o_valid},  32'd0);
        chk("rst_in_stall_wdata", o_Wdata,           32'd0);

        clr();
        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            cyc();
        end

        done = 1;
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
